// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared definitions for the iterative multiply/divide unit.
//   mdu_state_t    - control FSM states (2-bit encoding)
//   MDU_DIV0_QUOT  - quotient returned on divide by zero
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    localparam logic [31:0] MDU_DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_unit_abs_neg.sv
// mdu_abs_neg: conditional two's-complement negate.
//   value  [WIDTH-1:0] in  - operand
//   negate             in  - 1 = output -value, 0 = pass through
//   result [WIDTH-1:0] out - value or -value (wraps for the most negative value)
module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + 1'b1) : value;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MUL/MULTU/DIV/DIVU unit for the EX stage.
//   clk, rst_n          - clock, synchronous active-low reset
//   mul_ena, div_ena    - decoded multiply / divide in EX (divide wins if both)
//   mul_sign, div_sign  - signed variant select
//   a_in, b_in          - rs / rt operands, sampled only at start
//   flush               - aborts the operation in any state except DONE
//   stall_out           - holds PC, IF/ID and ID/EX while busy
//   done_out            - one-cycle pulse, hi_out/lo_out valid
//   hi_out, lo_out      - mul: product high/low; div: remainder/quotient
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul_ena,
    input  logic             div_ena,
    input  logic             mul_sign,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             flush,
    output logic             stall_out,
    output logic             done_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state, state_next;
    logic [CW-1:0]      count;
    logic               is_div, neg_res, neg_rem, b_zero;
    logic [WIDTH-1:0]   a_orig, b_abs;
    logic [2*WIDTH-1:0] acc, acc_next;

    logic               start, op_sign, a_sgn, b_sgn;
    logic [WIDTH-1:0]   a_abs, b_abs_in;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_hi, fix_lo;

    assign start   = (mul_ena | div_ena) & ~flush;
    assign op_sign = div_ena ? div_sign : mul_sign;
    assign a_sgn   = op_sign & a_in[WIDTH-1];
    assign b_sgn   = op_sign & b_in[WIDTH-1];

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.value(a_in), .negate(a_sgn), .result(a_abs));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.value(b_in), .negate(b_sgn), .result(b_abs_in));

    // acc is shared: mul keeps {partial product, remaining multiplier bits},
    // div keeps {partial remainder, dividend bits shifting into quotient bits}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_abs} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_abs};
        if (!is_div)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .negate(neg_res), .result(prod_fix));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_quot (.value(acc[WIDTH-1:0]), .negate(neg_res), .result(quot_fix));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_rem  (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(rem_fix));

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                fix_hi = a_orig;
                fix_lo = WIDTH'(MDU_DIV0_QUOT);
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end
    end

    always_comb begin
        state_next = state;
        stall_out  = 1'b0;
        case (state)
            MDU_IDLE: begin
                stall_out = start;
                if (start) state_next = MDU_CALC;
            end
            MDU_CALC: begin
                if (flush) begin
                    state_next = MDU_IDLE;
                end else begin
                    stall_out = 1'b1;
                    if (count == CW'(WIDTH-1)) state_next = MDU_FIX;
                end
            end
            MDU_FIX: begin
                if (flush) begin
                    state_next = MDU_IDLE;
                end else begin
                    stall_out  = 1'b1;
                    state_next = MDU_DONE;
                end
            end
            MDU_DONE: state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    assign done_out = (state == MDU_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= MDU_IDLE;
            count   <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_orig  <= '0;
            b_abs   <= '0;
            acc     <= '0;
        end else begin
            state <= state_next;
            if (state == MDU_IDLE && start) begin
                is_div  <= div_ena;
                a_orig  <= a_in;
                b_abs   <= b_abs_in;
                b_zero  <= (b_in == '0);
                neg_res <= a_sgn ^ b_sgn;
                neg_rem <= a_sgn;
                acc     <= {{WIDTH{1'b0}}, a_abs};
                count   <= '0;
            end
            if (state == MDU_CALC) begin
                acc   <= acc_next;
                count <= count + 1'b1;
            end
            if (state == MDU_FIX && !flush) begin
                hi_out <= fix_hi;
                lo_out <= fix_lo;
            end
        end
    end

endmodule
